// File: rtl/axi_rd_arbiter_mux.sv
// axi_rd_arbiter_mux: N-master AXI3 read (AR+R) arbiter/mux, one read outstanding at a time.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module axi_rd_arbiter_mux #(
    parameter int NM = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM*IW-1:0] m_arid,
    input  logic [NM*AW-1:0] m_araddr,
    input  logic [NM*4-1:0]  m_arlen,
    input  logic [NM*3-1:0]  m_arsize,
    input  logic [NM*2-1:0]  m_arburst,
    input  logic [NM*2-1:0]  m_arlock,
    input  logic [NM*4-1:0]  m_arcache,
    input  logic [NM*3-1:0]  m_arprot,
    input  logic [NM-1:0]    m_arvalid,
    output logic [NM-1:0]    m_arready,
    output logic [NM*IW-1:0] m_rid,
    output logic [NM*DW-1:0] m_rdata,
    output logic [NM*2-1:0]  m_rresp,
    output logic [NM-1:0]    m_rlast,
    output logic [NM-1:0]    m_rvalid,
    input  logic [NM-1:0]    m_rready,
    output logic [IW-1:0]    s_arid,
    output logic [AW-1:0]    s_araddr,
    output logic [3:0]       s_arlen,
    output logic [2:0]       s_arsize,
    output logic [1:0]       s_arburst,
    output logic [1:0]       s_arlock,
    output logic [3:0]       s_arcache,
    output logic [2:0]       s_arprot,
    output logic             s_arvalid,
    input  logic             s_arready,
    input  logic [IW-1:0]    s_rid,
    input  logic [DW-1:0]    s_rdata,
    input  logic [1:0]       s_rresp,
    input  logic             s_rlast,
    input  logic             s_rvalid,
    output logic             s_rready,
    output logic [NM-1:0]    grant
);
    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state;
    logic [GW-1:0] gi, win;
`ifdef AXI_RD_ARB_RR_EN
    logic [GW-1:0] rr_ptr;
    // lowest requester at or above rr_ptr wins; otherwise the scan wraps to the lowest requester
    always_comb begin
        win = '0;
        for (int j = NM - 1; j >= 0; j--)
            if (m_arvalid[j]) win = GW'(j);
        for (int j = NM - 1; j >= 0; j--)
            if (m_arvalid[j] && GW'(j) >= rr_ptr) win = GW'(j);
    end
`else
    always_comb begin
        win = '0;
        for (int j = NM - 1; j >= 0; j--)
            if (m_arvalid[j]) win = GW'(j);
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            gi    <= '0;
`ifdef AXI_RD_ARB_RR_EN
            rr_ptr <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (|m_arvalid) begin
                    state <= ADDR;
                    gi    <= win;
                    grant <= NM'(1) << win;
                end
                // a master withdrawing its request before the handshake releases the grant
                ADDR: if (!m_arvalid[gi]) begin
                    state <= IDLE;
                    grant <= '0;
                end else if (s_arready) begin
                    state <= DATA;
                end
                DATA: if (s_rvalid && m_rready[gi] && s_rlast) begin
                    state <= IDLE;
                    grant <= '0;
`ifdef AXI_RD_ARB_RR_EN
                    rr_ptr <= (int'(gi) == NM - 1) ? '0 : gi + 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        s_arid    = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_arlock  = '0;
        s_arcache = '0;
        s_arprot  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = '0;
        m_rvalid  = '0;
        if (state == ADDR) begin
            s_arid        = m_arid[gi*IW +: IW];
            s_araddr      = m_araddr[gi*AW +: AW];
            s_arlen       = m_arlen[gi*4 +: 4];
            s_arsize      = m_arsize[gi*3 +: 3];
            s_arburst     = m_arburst[gi*2 +: 2];
            s_arlock      = m_arlock[gi*2 +: 2];
            s_arcache     = m_arcache[gi*4 +: 4];
            s_arprot      = m_arprot[gi*3 +: 3];
            s_arvalid     = m_arvalid[gi];
            m_arready[gi] = s_arready;
        end
        if (state == DATA) begin
            m_rid[gi*IW +: IW]   = s_rid;
            m_rdata[gi*DW +: DW] = s_rdata;
            m_rresp[gi*2 +: 2]   = s_rresp;
            m_rlast[gi]          = s_rlast;
            m_rvalid[gi]         = s_rvalid;
            s_rready             = m_rready[gi];
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter_mux.sv
// tb_axi_rd_arbiter_mux: randomized bench for axi_rd_arbiter_mux against an arbitration/routing model.
// Expectations follow AXI_RD_ARB_RR_EN the same way the design does.
module tb_axi_rd_arbiter_mux;
    localparam int NM = 4, AW = 32, DW = 32, IW = 4;
    localparam int ARW = IW + AW + 18;
    logic clk = 1'b0;
    logic rst;
    logic [NM*IW-1:0] m_arid;
    logic [NM*AW-1:0] m_araddr;
    logic [NM*4-1:0]  m_arlen, m_arcache;
    logic [NM*3-1:0]  m_arsize, m_arprot;
    logic [NM*2-1:0]  m_arburst, m_arlock, m_rresp;
    logic [NM-1:0]    m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, grant;
    logic [NM*IW-1:0] m_rid;
    logic [NM*DW-1:0] m_rdata;
    logic [IW-1:0] s_arid, s_rid;
    logic [AW-1:0] s_araddr;
    logic [3:0] s_arlen, s_arcache;
    logic [2:0] s_arsize, s_arprot;
    logic [1:0] s_arburst, s_arlock, s_rresp;
    logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [DW-1:0] s_rdata;
    int errors = 0, checks = 0, rr_m = 0;
    logic [AW-1:0] f_addr[NM];
    logic [IW-1:0] f_id[NM];
    logic [3:0] f_len[NM], f_cache[NM];
    logic [2:0] f_size[NM], f_prot[NM];
    logic [1:0] f_burst[NM], f_lock[NM];
    always #5 clk = ~clk;
    axi_rd_arbiter_mux #(.NM(NM), .AW(AW), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache),
        .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache),
        .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready), .grant(grant)
    );
    wire [ARW-1:0] ar_act = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot};
    function automatic logic [ARW-1:0] ar_exp(int g);
        return {f_id[g], f_addr[g], f_len[g], f_size[g], f_burst[g], f_lock[g], f_cache[g], f_prot[g]};
    endfunction
    // arbitration rule: scan from the round-robin pointer (or from 0 for fixed priority)
    function automatic int pick(logic [NM-1:0] r, int ptr);
`ifdef AXI_RD_ARB_RR_EN
        for (int k = 0; k < NM; k++) if (r[(ptr + k) % NM]) return (ptr + k) % NM;
`else
        for (int k = 0; k < NM; k++) if (r[k] && ptr >= 0) return k;
`endif
        return 0;
    endfunction
    task automatic apply_fields();
        for (int i = 0; i < NM; i++) begin
            m_arid[i*IW +: IW] = f_id[i];
            m_araddr[i*AW +: AW] = f_addr[i];
            m_arlen[i*4 +: 4] = f_len[i];
            m_arsize[i*3 +: 3] = f_size[i];
            m_arburst[i*2 +: 2] = f_burst[i];
            m_arlock[i*2 +: 2] = f_lock[i];
            m_arcache[i*4 +: 4] = f_cache[i];
            m_arprot[i*3 +: 3] = f_prot[i];
        end
    endtask
    task automatic rand_fields();
        for (int i = 0; i < NM; i++) begin
            f_id[i] = IW'($urandom);
            f_addr[i] = AW'($urandom);
            f_len[i] = 4'($urandom_range(0, 5));
            f_size[i] = 3'($urandom);
            f_burst[i] = 2'($urandom);
            f_lock[i] = 2'($urandom);
            f_cache[i] = 4'($urandom);
            f_prot[i] = 3'($urandom);
        end
        apply_fields();
    endtask
    // one full transaction: arbitrate, AR with optional stall, R beats, idle bubble (or reset mid-burst)
    task automatic do_round(input logic [NM-1:0] req, input int stall, input bit rand_rdy, input int rst_after);
        int g, beat, cyc;
        logic [NM*IW-1:0] e_rid;
        logic [NM*DW-1:0] e_rdata;
        logic [NM*2-1:0] e_rresp;
        logic [NM-1:0] e_rl, e_rv;
        g = pick(req, rr_m);
        m_arvalid = req;
        s_arready = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (grant !== NM'(1) << g) begin errors++; $display("FAIL grant got %b exp %b", grant, NM'(1) << g); end
        checks++;
        if (s_arvalid !== 1'b1 || ar_act !== ar_exp(g)) begin
            errors++; $display("FAIL ar_fields got %b/%h exp 1/%h", s_arvalid, ar_act, ar_exp(g));
        end
        for (int c = 0; c < stall; c++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (m_arready !== '0 || ar_act !== ar_exp(g) || grant !== NM'(1) << g) begin
                errors++; $display("FAIL ar_stall got rdy %b ar %h exp rdy 0 ar %h", m_arready, ar_act, ar_exp(g));
            end
        end
        s_arready = 1'b1;
        #1;
        checks++;
        if (m_arready !== NM'(1) << g) begin errors++; $display("FAIL arready got %b exp %b", m_arready, NM'(1) << g); end
        @(posedge clk); @(negedge clk);
        s_arready = 1'b0;
        m_arvalid[g] = 1'b0;
        beat = 0;
        cyc = 0;
        while (beat <= int'(f_len[g]) && cyc < 200) begin
            if (rst_after >= 0 && beat == rst_after) break;
            s_rvalid = 1'($urandom_range(0, 1));
            m_rready = rand_rdy ? NM'($urandom) : '1;
            s_rdata = DW'($urandom);
            s_rresp = 2'($urandom);
            s_rid = f_id[g];
            s_rlast = (beat == int'(f_len[g]));
            #1;
            e_rid = '0; e_rdata = '0; e_rresp = '0; e_rl = '0; e_rv = '0;
            e_rid[g*IW +: IW] = s_rid;
            e_rdata[g*DW +: DW] = s_rdata;
            e_rresp[g*2 +: 2] = s_rresp;
            e_rl[g] = s_rlast;
            e_rv[g] = s_rvalid;
            checks++;
            if ({m_rid, m_rdata, m_rresp, m_rlast, m_rvalid, s_rready} !== {e_rid, e_rdata, e_rresp, e_rl, e_rv, m_rready[g]}) begin
                errors++;
                $display("FAIL r_route beat %0d got %h %h %b %b rdy %b exp %h %h %b %b rdy %b", beat,
                         m_rid, m_rdata, m_rlast, m_rvalid, s_rready, e_rid, e_rdata, e_rl, e_rv, m_rready[g]);
            end
            @(posedge clk);
            if (s_rvalid && m_rready[g]) beat++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin errors++; $display("FAIL r_timeout got %0d beats exp %0d", beat, f_len[g] + 1); end
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        if (rst_after >= 0) begin
            rst = 1'b1;
            m_arvalid = '0;
            s_rvalid = 1'b1;
            @(posedge clk); @(negedge clk);
            checks++;
            if (grant !== '0 || s_rready !== 1'b0 || m_rvalid !== '0 || s_arvalid !== 1'b0) begin
                errors++; $display("FAIL reset_mid got grant %b rready %b rvalid %b exp 0", grant, s_rready, m_rvalid);
            end
            rst = 1'b0;
            s_rvalid = 1'b0;
            rr_m = 0;
        end else begin
            rr_m = (g + 1) % NM;
            checks++;
            if (grant !== '0 || s_arvalid !== 1'b0 || s_rready !== 1'b0) begin
                errors++; $display("FAIL idle_bubble got grant %b arvalid %b exp 0", grant, s_arvalid);
            end
        end
    endtask
    task automatic test_reset();
        checks++;
        if ({grant, s_arvalid, s_rready, m_arready, m_rvalid, m_rlast} !== '0 || ar_act !== '0) begin
            errors++; $display("FAIL reset got grant %b arvalid %b ar %h exp 0", grant, s_arvalid, ar_act);
        end
    endtask
    task automatic test_single();
        rand_fields();
        f_addr[1] = 32'h1FC0_0000;
        f_len[1] = 4'd3;
        apply_fields();
        do_round(4'b0010, 0, 0, -1);
    endtask
    task automatic test_contention();
        repeat (4) begin rand_fields(); do_round(4'b0011, 0, 0, -1); end
    endtask
    task automatic test_backpressure();
        rand_fields();
        do_round(4'b0100, 5, 1, -1);
    endtask
    task automatic test_wrap();
        rand_fields();
        do_round(4'b1000, 0, 0, -1);
        do_round(4'b0101, 0, 0, -1);
    endtask
    task automatic test_ar_drop();
        int g;
        rand_fields();
        g = pick(4'b0110, rr_m);
        m_arvalid = 4'b0110;
        @(posedge clk); @(negedge clk);
        checks++;
        if (grant !== NM'(1) << g) begin errors++; $display("FAIL drop_grant got %b exp %b", grant, NM'(1) << g); end
        m_arvalid = '0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (grant !== '0 || s_arvalid !== 1'b0) begin errors++; $display("FAIL drop_idle got %b exp 0", grant); end
    endtask
    task automatic test_isolation();
        m_arvalid = '0;
        s_rvalid = 1'b1;
        s_rlast = 1'b1;
        m_rready = '1;
        #1;
        checks++;
        if (s_rready !== 1'b0 || m_rvalid !== '0 || m_rlast !== '0) begin
            errors++; $display("FAIL isolation got rready %b rvalid %b exp 0", s_rready, m_rvalid);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL isolation_grant got %b exp 0", grant); end
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
    endtask
    task automatic test_random();
        repeat (20) begin
            rand_fields();
            do_round(NM'($urandom_range(1, (1 << NM) - 1)), $urandom_range(0, 3), 1, -1);
        end
    endtask
    task automatic test_reset_mid();
        rand_fields();
        f_len[0] = 4'd3;
        apply_fields();
        do_round(4'b0001, 0, 1, 2);
        rand_fields();
        do_round(4'b0011, 1, 1, -1);
    endtask
    initial begin
        rst = 1'b1;
        m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_arlock = '0; m_arcache = '0; m_arprot = '0; m_arvalid = '0; m_rready = '0;
        s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        test_ar_drop();
        test_isolation();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
